// File: rtl/nla_feeder_if.sv
// nla_feeder_if: the signals between nla_feeder, the host streams and the
// approximation-engine controller/datapath.
//   Host sample stream     : sample_valid/sample_ready/sample_data
//   Host coefficient stream: coeff_valid/coeff_ready/coeff_data/coeff_last, coeff_flush
//   Controller handshake   : wr_en_signal, wr_en_coeff, redo, LD_result,
//                            start_signal, start_coeff, wr_ptr_coeff
//   Buffer write ports     : sig_we/sig_wdata, coeff_we/coeff_waddr/coeff_wdata
//   Result stream          : res_data (datapath), out_valid/out_ready/out_data (host)
//   Status                 : coeff_trunc
// The slave modport is the feeder's view. The master modport is the view of
// the host and controller.
interface nla_feeder_if #(
  parameter int DATA_W     = 16,
  parameter int ADDR_LINES = 4
);
  logic                  sample_valid;
  logic                  sample_ready;
  logic [DATA_W-1:0]     sample_data;
  logic                  coeff_valid;
  logic                  coeff_ready;
  logic [DATA_W-1:0]     coeff_data;
  logic                  coeff_last;
  logic                  coeff_flush;
  logic                  wr_en_signal;
  logic                  wr_en_coeff;
  logic                  redo;
  logic                  LD_result;
  logic [DATA_W-1:0]     res_data;
  logic                  sig_we;
  logic [DATA_W-1:0]     sig_wdata;
  logic                  coeff_we;
  logic [ADDR_LINES-1:0] coeff_waddr;
  logic [DATA_W-1:0]     coeff_wdata;
  logic                  start_signal;
  logic                  start_coeff;
  logic [ADDR_LINES-1:0] wr_ptr_coeff;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_data;
  logic                  coeff_trunc;

  modport slave (
    input  sample_valid, sample_data, coeff_valid, coeff_data, coeff_last,
           coeff_flush, wr_en_signal, wr_en_coeff, redo, LD_result, res_data,
           out_ready,
    output sample_ready, coeff_ready, sig_we, sig_wdata, coeff_we, coeff_waddr,
           coeff_wdata, start_signal, start_coeff, wr_ptr_coeff, out_valid,
           out_data, coeff_trunc
  );

  modport master (
    output sample_valid, sample_data, coeff_valid, coeff_data, coeff_last,
           coeff_flush, wr_en_signal, wr_en_coeff, redo, LD_result, res_data,
           out_ready,
    input  sample_ready, coeff_ready, sig_we, sig_wdata, coeff_we, coeff_waddr,
           coeff_wdata, start_signal, start_coeff, wr_ptr_coeff, out_valid,
           out_data, coeff_trunc
  );
endinterface

// File: rtl/nla_feeder.sv
// nla_feeder: host-side sequencer for the nonlinear approximation engine.
// It writes host samples and coefficient sets into the engine's buffers when
// the controller requests them, and raises start_signal and start_coeff.
// It returns each polynomial result to the host. Only one sample is in
// flight at a time.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   bus   - nla_feeder_if.slave (host streams, controller handshake, buffer
//           write ports, result stream)
module nla_feeder #(
  parameter int DATA_W     = 16,
  parameter int ADDR_LINES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  nla_feeder_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, BUSY, CAPT} state_t;

  localparam logic [ADDR_LINES-1:0] WP_MAX = '1;

  state_t                state, state_nxt;
  logic                  start_signal_q;
  logic                  start_coeff_q;
  logic [ADDR_LINES-1:0] wr_ptr_q;
  logic [ADDR_LINES-1:0] wp;
  logic [DATA_W-1:0]     out_data_q;
  logic                  out_valid_q;
  logic                  trunc_q;
  logic                  flush_pend;

  logic                  sample_ready_w;
  logic                  coeff_ready_w;
  logic                  sample_hs;
  logic                  coeff_hs;
  logic                  set_done;
  logic                  flush_apply;
  logic                  go_busy;

  // Ready terms include rst_n so that nothing handshakes while reset is held.
  assign sample_ready_w = rst_n & bus.wr_en_signal & (state == IDLE) &
                          ~start_signal_q & ~out_valid_q;
  assign coeff_ready_w  = rst_n & bus.wr_en_coeff & ~start_coeff_q;
  assign sample_hs      = bus.sample_valid & sample_ready_w;
  assign coeff_hs       = bus.coeff_valid & coeff_ready_w;

  // A set closes on coeff_last or when the buffer top is reached. The
  // pointer stays put, so the last written index can be reported directly.
  assign set_done       = bus.coeff_last | (wp == WP_MAX);

  // A flush counts in the same cycle as its pulse. A pending flush waits
  // until no sample is committed to the current coefficient set.
  assign flush_apply    = (flush_pend | bus.coeff_flush) &
                          (state == IDLE) & ~start_signal_q;
  assign go_busy        = (state == IDLE) & bus.redo;

  assign bus.sample_ready = sample_ready_w;
  assign bus.coeff_ready  = coeff_ready_w;
  assign bus.sig_we       = sample_hs;
  assign bus.sig_wdata    = bus.sample_data;
  assign bus.coeff_we     = coeff_hs;
  assign bus.coeff_waddr  = wp;
  assign bus.coeff_wdata  = bus.coeff_data;
  assign bus.start_signal = start_signal_q;
  assign bus.start_coeff  = start_coeff_q;
  assign bus.wr_ptr_coeff = wr_ptr_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.coeff_trunc  = trunc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.redo)      state_nxt = BUSY;
      BUSY:    if (bus.LD_result) state_nxt = CAPT;
      CAPT:                       state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Sample flag and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_signal_q <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
    end else begin
      if (sample_hs)    start_signal_q <= 1'b1;
      else if (go_busy) start_signal_q <= 1'b0;

      // While out_valid is high, a new sample cannot reach CAPT, so out_data
      // holds until the host takes it.
      if (state == CAPT) begin
        out_data_q  <= bus.res_data;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Coefficient loading and flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_coeff_q <= 1'b0;
      wr_ptr_q      <= '0;
      wp            <= '0;
      trunc_q       <= 1'b0;
      flush_pend    <= 1'b0;
    end else if (flush_apply) begin
      start_coeff_q <= 1'b0;
      wr_ptr_q      <= '0;
      wp            <= '0;
      trunc_q       <= 1'b0;
      flush_pend    <= 1'b0;
    end else begin
      if (bus.coeff_flush) flush_pend <= 1'b1;
      if (coeff_hs) begin
        if (set_done) begin
          start_coeff_q <= 1'b1;
          wr_ptr_q      <= wp;
          if (!bus.coeff_last) trunc_q <= 1'b1;
        end else begin
          wp <= wp + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nla_feeder.sv
module tb_nla_feeder;
  localparam int DATA_W     = 16;
  localparam int ADDR_LINES = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nla_feeder_if #(.DATA_W(DATA_W), .ADDR_LINES(ADDR_LINES)) bus ();

  nla_feeder #(.DATA_W(DATA_W), .ADDR_LINES(ADDR_LINES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [DATA_W-1:0]     data;
    logic                  last;
    logic                  exp_ready;
    logic [ADDR_LINES-1:0] exp_addr;
    logic                  exp_start;
    logic [ADDR_LINES-1:0] exp_wptr;
    logic                  exp_trunc;
  } beat_t;

  beat_t             vec [24];
  logic [DATA_W-1:0] coef_model [16];
  int                mdl_cnt;
  logic [DATA_W-1:0] exp_q [$];
  int                n_checks = 0;
  int                n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] poly(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] y;
    y = '0;
    for (int k = 0; k < mdl_cnt; k++) y = y * x + coef_model[k];
    return y;
  endfunction

  task automatic apply_beats(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      bus.coeff_valid = 1'b1;
      bus.coeff_data  = vec[i].data;
      bus.coeff_last  = vec[i].last;
      #1;
      chk($sformatf("coeff_ready[%0d]", i), bus.coeff_ready, vec[i].exp_ready);
      chk($sformatf("coeff_we[%0d]", i), bus.coeff_we, vec[i].exp_ready);
      if (vec[i].exp_ready) begin
        chk($sformatf("coeff_waddr[%0d]", i), bus.coeff_waddr, vec[i].exp_addr);
        chk($sformatf("coeff_wdata[%0d]", i), bus.coeff_wdata, vec[i].data);
        coef_model[vec[i].exp_addr] = vec[i].data;
      end
      tick();
      chk($sformatf("start_coeff[%0d]", i), bus.start_coeff, vec[i].exp_start);
      chk($sformatf("wr_ptr_coeff[%0d]", i), bus.wr_ptr_coeff, vec[i].exp_wptr);
      chk($sformatf("coeff_trunc[%0d]", i), bus.coeff_trunc, vec[i].exp_trunc);
    end
    bus.coeff_valid = 1'b0;
    bus.coeff_last  = 1'b0;
  endtask

  task automatic send_sample(input logic [DATA_W-1:0] x);
    bus.sample_valid = 1'b1;
    bus.sample_data  = x;
    #1;
    chk("sample_ready", bus.sample_ready, 1);
    chk("sig_we", bus.sig_we, 1);
    chk("sig_wdata", bus.sig_wdata, x);
    tick();
    bus.sample_valid = 1'b0;
    chk("start_signal_set", bus.start_signal, 1);
  endtask

  task automatic drain();
    logic got;
    got = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 8 && !got; c++) begin
      if (bus.out_valid) begin
        got = 1'b1;
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL result: got 0x%0h, expected nothing", bus.out_data);
        end else begin
          chk("result", bus.out_data, exp_q.pop_front());
        end
      end
      tick();
    end
    if (!got) begin
      n_checks++; n_errors++;
      $display("FAIL result_timeout: got out_valid=0, expected 1 within 8 cycles");
    end
    bus.out_ready = 1'b0;
    chk("out_valid_cleared", bus.out_valid, 0);
  endtask

  task automatic compute(input logic [DATA_W-1:0] x, input int hold, input logic do_flush);
    logic [DATA_W-1:0] y;
    y = poly(x);
    chk("start_coeff_pre", bus.start_coeff, 1);
    bus.redo = 1'b1;
    tick();
    bus.redo = 1'b0;
    chk("start_signal_clr", bus.start_signal, 0);
    chk("sample_ready_busy", bus.sample_ready, 0);
    bus.res_data = ~y;
    if (do_flush) bus.coeff_flush = 1'b1;
    tick();
    bus.coeff_flush = 1'b0;
    if (do_flush) chk("flush_deferred_busy", bus.start_coeff, 1);
    bus.LD_result = 1'b1;
    tick();
    bus.LD_result = 1'b0;
    bus.res_data  = y;
    exp_q.push_back(y);
    chk("out_valid_in_capt", bus.out_valid, 0);
    tick();
    bus.res_data = ~y;
    chk("out_valid_rise", bus.out_valid, 1);
    if (do_flush) chk("flush_deferred_capt", bus.start_coeff, 1);
    for (int h = 0; h < hold; h++) begin
      bus.sample_valid = 1'b1;
      bus.sample_data  = x + 1'b1;
      #1;
      chk("sample_ready_hold", bus.sample_ready, 0);
      chk("sig_we_hold", bus.sig_we, 0);
      if (exp_q.size() != 0) chk("out_data_hold", bus.out_data, exp_q[0]);
      tick();
    end
    bus.sample_valid = 1'b0;
    drain();
    if (do_flush) begin
      chk("flush_start_coeff", bus.start_coeff, 0);
      chk("flush_wr_ptr", bus.wr_ptr_coeff, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // {3,2,1} set, loaded from reset
    vec[0] = '{16'd3, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0};
    vec[1] = '{16'd2, 1'b0, 1'b1, 4'd1, 1'b0, 4'd0, 1'b0};
    vec[2] = '{16'd1, 1'b1, 1'b1, 4'd2, 1'b1, 4'd2, 1'b0};
    // 17 beats without coeff_last, loaded after a flush
    for (int i = 0; i < 17; i++) begin
      vec[3+i].data      = 16'(i + 1);
      vec[3+i].last      = 1'b0;
      vec[3+i].exp_ready = (i < 16);
      vec[3+i].exp_addr  = 4'((i < 16) ? i : 15);
      vec[3+i].exp_start = (i >= 15);
      vec[3+i].exp_wptr  = 4'((i >= 15) ? 15 : 0);
      vec[3+i].exp_trunc = (i >= 15);
    end
    // {1,0,2,1} set
    vec[20] = '{16'd1, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0};
    vec[21] = '{16'd0, 1'b0, 1'b1, 4'd1, 1'b0, 4'd0, 1'b0};
    vec[22] = '{16'd2, 1'b0, 1'b1, 4'd2, 1'b0, 4'd0, 1'b0};
    vec[23] = '{16'd1, 1'b1, 1'b1, 4'd3, 1'b1, 4'd3, 1'b0};

    bus.sample_valid = 0; bus.sample_data = '0;
    bus.coeff_valid = 0; bus.coeff_data = '0; bus.coeff_last = 0; bus.coeff_flush = 0;
    bus.wr_en_signal = 1; bus.wr_en_coeff = 1;
    bus.redo = 0; bus.LD_result = 0; bus.res_data = '0; bus.out_ready = 0;
    rst_n = 1'b0;
    #2;
    chk("rst_sample_ready", bus.sample_ready, 0);
    chk("rst_coeff_ready", bus.coeff_ready, 0);
    chk("rst_start_signal", bus.start_signal, 0);
    chk("rst_start_coeff", bus.start_coeff, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_sample_ready", bus.sample_ready, 1);
    chk("post_rst_coeff_ready", bus.coeff_ready, 1);

    // Load {3,2,1}, sample 5 -> 86
    apply_beats(0, 3);
    mdl_cnt = 3;
    send_sample(16'd5);
    compute(16'd5, 0, 1'b0);

    // Second sample with the same coefficients, result held for 10 cycles
    send_sample(16'd7);
    chk("no_coeff_ready_reuse", bus.coeff_ready, 0);
    compute(16'd7, 10, 1'b0);
    chk("start_coeff_persist", bus.start_coeff, 1);

    // Flush while BUSY, then fresh load which truncates at the buffer top
    send_sample(16'd5);
    compute(16'd5, 0, 1'b1);
    send_sample(16'd2);
    chk("start_coeff_after_flush", bus.start_coeff, 0);
    apply_beats(3, 17);
    mdl_cnt = 16;
    compute(16'd2, 0, 1'b0);

    // Sample handshake and flush in the same IDLE cycle
    bus.sample_valid = 1'b1;
    bus.sample_data  = 16'd9;
    bus.coeff_flush  = 1'b1;
    #1;
    chk("simul_sig_we", bus.sig_we, 1);
    tick();
    bus.sample_valid = 1'b0;
    bus.coeff_flush  = 1'b0;
    chk("simul_start_signal", bus.start_signal, 1);
    chk("simul_start_coeff", bus.start_coeff, 0);
    chk("simul_trunc_clr", bus.coeff_trunc, 0);
    chk("simul_wr_ptr", bus.wr_ptr_coeff, 0);
    chk("simul_coeff_ready_on", bus.coeff_ready, 1);
    bus.wr_en_coeff = 1'b0;
    #1;
    chk("simul_coeff_ready_off", bus.coeff_ready, 0);
    bus.wr_en_coeff = 1'b1;

    // Reset in BUSY after 2 of 4 coefficients
    apply_beats(20, 2);
    bus.redo = 1'b1;
    tick();
    bus.redo = 1'b0;
    chk("busy_sample_ready", bus.sample_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_start_signal", bus.start_signal, 0);
    chk("arst_start_coeff", bus.start_coeff, 0);
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_coeff_ready", bus.coeff_ready, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("arst_idle_sample_ready", bus.sample_ready, 1);
    send_sample(16'd3);
    apply_beats(20, 4);
    mdl_cnt = 4;
    compute(16'd3, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
